// File: rtl/led_matrix_pkg.sv
// Shared types and default sizes for the LED matrix datapath
// (refresh sequencer, serial encoder and SPI frame writer).
package led_matrix_pkg;

  localparam int PIXEL_W        = 24;
  localparam int DEF_NUM_PIXELS = 64;
  localparam int DEF_GAP_CYCLES = 600;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_GAP     = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/led_gap_timer.sv
// Loadable down-counter timing the latch gap; zero is high while the count is 0.
module led_gap_timer #(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             dec_en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/frame_refresh_sequencer.sv
// Sequences one LED-matrix refresh: fetch each pixel of the displayed bank, hand it
// to the bit encoder, wait for the encoder to drain, then hold the latch gap.
module frame_refresh_sequencer
  import led_matrix_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W     = 6,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               frame_req,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               buf_sel,
  output logic               mem_rd_en,
  output logic [ADDR_W:0]    mem_rd_addr,
  input  logic [PIXEL_W-1:0] mem_rd_data,
  output logic               pix_valid,
  output logic [PIXEL_W-1:0] pix_data,
  input  logic               pix_ready,
  input  logic               enc_idle,
  output logic               busy,
  output logic               frame_done
);

  localparam int                CNT_W    = $clog2(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  fsm_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               buf_sel_q, buf_sel_d;
  logic               req_pend_q, req_pend_d;
  logic               swap_pend_q, swap_pend_d;
  logic               frame_req_q, swap_req_q;
  logic               pix_valid_q, pix_valid_d;
  logic [PIXEL_W-1:0] pix_data_q, pix_data_d;
  logic               swap_ack_q, swap_ack_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic start_s;
  logic gap_load_s;
  logic gap_dec_s;
  logic gap_zero_s;
  logic req_any_s;
  logic swap_any_s;

  assign req_any_s  = frame_req_q | req_pend_q;
  assign swap_any_s = swap_req_q | swap_pend_q;
  assign gap_dec_s  = (state_q == ST_GAP);

  led_gap_timer #(
    .CNT_W (CNT_W)
  ) u_gap_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (gap_load_s),
    .dec_en   (gap_dec_s),
    .load_val (GAP_LOAD),
    .zero     (gap_zero_s)
  );

  // State, bookkeeping and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= {ADDR_W{1'b0}};
      buf_sel_q    <= 1'b0;
      req_pend_q   <= 1'b0;
      swap_pend_q  <= 1'b0;
      frame_req_q  <= 1'b0;
      swap_req_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= {PIXEL_W{1'b0}};
      swap_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_sel_q    <= buf_sel_d;
      req_pend_q   <= req_pend_d;
      swap_pend_q  <= swap_pend_d;
      frame_req_q  <= frame_req;
      swap_req_q   <= swap_req;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      swap_ack_q   <= swap_ack_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state; a frame start (from IDLE or straight out of GAP) also commits a pending swap.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_sel_d   = buf_sel_q;
    req_pend_d  = req_pend_q | (frame_req_q & (state_q != ST_IDLE));
    swap_pend_d = swap_pend_q | swap_req_q;
    start_s     = 1'b0;
    gap_load_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_PRESENT;
      ST_PRESENT: begin
        if (pix_valid_q && pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_DRAIN: begin
        if (enc_idle) begin
          state_d    = ST_GAP;
          gap_load_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_GAP: begin
        if (gap_zero_s && req_any_s) begin
          start_s = 1'b1;
        end else if (gap_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_s) begin
      state_d    = ST_FETCH;
      idx_d      = {ADDR_W{1'b0}};
      req_pend_d = 1'b0;
      if (swap_any_s) begin
        buf_sel_d   = ~buf_sel_q;
        swap_pend_d = 1'b0;
      end else begin
        buf_sel_d = buf_sel_q;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Registered-output next values, aligned with the state they describe.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    pix_valid_d  = (state_d == ST_PRESENT);
    swap_ack_d   = start_s & swap_any_s;
    frame_done_d = (state_q == ST_GAP) & gap_zero_s;
    if (state_q == ST_WAIT) begin
      pix_data_d = mem_rd_data;
    end else begin
      pix_data_d = pix_data_q;
    end
  end

  // The read strobe and address decode directly so the buffer sees them in FETCH.
  assign mem_rd_en   = (state_q == ST_FETCH);
  assign mem_rd_addr = {buf_sel_q, idx_q};

  assign swap_ack   = swap_ack_q;
  assign buf_sel    = buf_sel_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_refresh_sequencer.sv
// Directed and randomized checks of frame_refresh_sequencer against a
// transaction-level model (expected pixel stream per frame, bank per frame).
module tb_frame_refresh_sequencer;

  localparam int NP = 4;
  localparam int AW = 6;
  localparam int GC = 10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        frame_req;
  logic        swap_req;
  logic        pix_ready;
  logic        enc_idle;
  logic        swap_ack;
  logic        buf_sel;
  logic        mem_rd_en;
  logic [AW:0] mem_rd_addr;
  logic [23:0] mem_rd_data = 24'h000000;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        busy;
  logic        frame_done;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] hs_q[$];
  int          done_cnt = 0;
  logic        stall_q = 1'b0;
  logic [23:0] stall_data = 24'h000000;

  frame_refresh_sequencer #(
    .NUM_PIXELS (NP),
    .ADDR_W     (AW),
    .GAP_CYCLES (GC)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .frame_req   (frame_req),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .buf_sel     (buf_sel),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .enc_idle    (enc_idle),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 CLK = ~CLK;

  // Frame buffer: word = 0x0A0B00 + address, data valid the cycle after the strobe.
  always @(posedge CLK) begin
    if (mem_rd_en) mem_rd_data <= 24'h0A0B00 + 24'(mem_rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic bank, input int idx);
    return 24'h0A0B00 + (bank ? 24'(1 << AW) : 24'h000000) + 24'(idx);
  endfunction

  // Monitor: record transfers, count frame_done, and require a stalled pixel to stay put.
  always @(posedge CLK) begin
    if (RESET) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(pix_valid), 32'd1);
        check("hold_data", 32'(pix_data), 32'(stall_data));
      end
      if (pix_valid && pix_ready) hs_q.push_back(pix_data);
      if (frame_done) done_cnt++;
      stall_q    = pix_valid && !pix_ready;
      stall_data = pix_data;
    end
  end

  task automatic check_frame(input string tag, input logic bank);
    check({tag, "_npix"}, 32'(hs_q.size()), 32'(NP));
    for (int i = 0; i < NP; i++) begin
      if (i < hs_q.size()) check({tag, "_pix"}, 32'(hs_q[i]), 32'(exp_pix(bank, i)));
    end
    hs_q.delete();
  endtask

  task automatic pulse_req(input logic with_swap);
    frame_req = 1'b1;
    swap_req  = with_swap;
    @(negedge CLK);
    frame_req = 1'b0;
    swap_req  = 1'b0;
  endtask

  task automatic wait_pixels(input string tag);
    int cyc = 0;
    while (hs_q.size() < NP && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    check(tag, 32'(hs_q.size()), 32'(NP));
  endtask

  task automatic wait_done_to(input string tag, input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 400) begin
      @(negedge CLK);
      cyc++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int   cyc;
    int   base;
    int   mode;
    logic e_rd, e_vld, e_busy, e_done, bad, bank_m, pend_m;

    RESET = 1'b1; frame_req = 1'b0; swap_req = 1'b0; pix_ready = 1'b1; enc_idle = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_buf_sel", 32'(buf_sel), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_swap_ack", 32'(swap_ack), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Single frame, no backpressure: cycle-exact timeline from the sampling edge.
    pulse_req(1'b0);
    for (int c = 0; c <= 3 * NP + GC + 4; c++) begin
      if (c > 0) @(negedge CLK);
      e_rd   = (c >= 1) && (c <= 3 * NP - 2) && ((c - 1) % 3 == 0);
      e_vld  = (c >= 3) && (c <= 3 * NP) && (c % 3 == 0);
      e_busy = (c >= 1) && (c <= 3 * NP + 1 + GC);
      e_done = (c == 3 * NP + 2 + GC);
      check("t1_rd_en", 32'(mem_rd_en), 32'(e_rd));
      check("t1_pix_valid", 32'(pix_valid), 32'(e_vld));
      check("t1_busy", 32'(busy), 32'(e_busy));
      check("t1_frame_done", 32'(frame_done), 32'(e_done));
      if (e_rd) check("t1_rd_addr", 32'(mem_rd_addr), 32'((c - 1) / 3));
      if (e_vld) check("t1_pix_data", 32'(pix_data), 32'(exp_pix(1'b0, c / 3 - 1)));
    end
    check_frame("t1", 1'b0);

    // Backpressure on pixel 2 for five cycles.
    base = done_cnt;
    pulse_req(1'b0);
    cyc = 0;
    while (!(pix_valid === 1'b1 && pix_data === exp_pix(1'b0, 2)) && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check("t2_reach_pix2", 32'(pix_data), 32'(exp_pix(1'b0, 2)));
    pix_ready = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("t2_stall_valid", 32'(pix_valid), 32'd1);
      check("t2_stall_data", 32'(pix_data), 32'(exp_pix(1'b0, 2)));
      check("t2_stall_no_read", 32'(mem_rd_en), 32'd0);
    end
    pix_ready = 1'b1;
    wait_done_to("t2_done", base + 1);
    check_frame("t2", 1'b0);

    // Three requests during the gap collapse into one back-to-back frame.
    base = done_cnt;
    pulse_req(1'b0);
    wait_pixels("t3_pix");
    @(negedge CLK); pulse_req(1'b0);
    @(negedge CLK); pulse_req(1'b0);
    @(negedge CLK); pulse_req(1'b0);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check("t3_done_pulse", 32'(frame_done), 32'd1);
    check("t3_direct_fetch", 32'(mem_rd_en), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_rd_addr", 32'(mem_rd_addr), 32'd0);
    check_frame("t3a", 1'b0);
    wait_done_to("t3_second_done", base + 2);
    check_frame("t3b", 1'b0);
    repeat (40) @(negedge CLK);
    check("t3_two_done_only", 32'(done_cnt), 32'(base + 2));
    check("t3_idle", 32'(busy), 32'd0);

    // Swap requested mid-frame takes effect only at the next frame start.
    pulse_req(1'b0);
    repeat (5) @(negedge CLK);
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    base = done_cnt;
    bad = 1'b0;
    cyc = 0;
    while (done_cnt == base && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (buf_sel !== 1'b0 || swap_ack !== 1'b0) bad = 1'b1;
    end
    check("t4_no_mid_swap", 32'(bad), 32'd0);
    check_frame("t4a", 1'b0);
    pulse_req(1'b0);
    @(negedge CLK);
    check("t4_swap_ack", 32'(swap_ack), 32'd1);
    check("t4_buf_sel", 32'(buf_sel), 32'd1);
    check("t4_rd_en", 32'(mem_rd_en), 32'd1);
    check("t4_first_addr", 32'(mem_rd_addr), 32'h40);
    @(negedge CLK);
    check("t4_ack_one_cycle", 32'(swap_ack), 32'd0);
    wait_done_to("t4_done", base + 2);
    check_frame("t4b", 1'b1);

    // Encoder busy for 20 cycles after the last transfer delays the gap by 20.
    enc_idle = 1'b0;
    pulse_req(1'b0);
    wait_pixels("t5_pix");
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 20) enc_idle = 1'b1;
    end
    check("t5_done_delay", 32'(cyc), 32'(20 + 1 + GC));
    check("t5_busy_end", 32'(busy), 32'd0);
    check_frame("t5", 1'b1);
    @(negedge CLK);

    // Reset while a pixel is presented.
    pix_ready = 1'b0;
    pulse_req(1'b0);
    cyc = 0;
    while (pix_valid !== 1'b1 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    check("t6_reach_present", 32'(pix_valid), 32'd1);
    base = done_cnt;
    #2 RESET = 1'b1;
    #1;
    check("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("t6_rst_buf_sel", 32'(buf_sel), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    pix_ready = 1'b1;
    hs_q.delete();
    repeat (5) @(negedge CLK);
    check("t6_no_done", 32'(done_cnt), 32'(base));
    check("t6_idle", 32'(busy), 32'd0);
    pulse_req(1'b0);
    @(negedge CLK);
    check("t6_rd_en", 32'(mem_rd_en), 32'd1);
    check("t6_rd_addr", 32'(mem_rd_addr), 32'd0);
    wait_done_to("t6_done", base + 1);
    check_frame("t6", 1'b0);

    // Random backpressure, drain timing and swap placement against the bank model.
    bank_m = 1'b0;
    pend_m = 1'b0;
    for (int f = 0; f < 8; f++) begin
      mode = $urandom_range(0, 2);
      if (pend_m || mode == 2) bank_m = ~bank_m;
      pend_m = 1'b0;
      base = done_cnt;
      pulse_req(mode == 2);
      cyc = 0;
      while (done_cnt == base && cyc < 400) begin
        pix_ready = ($urandom_range(0, 1) == 1);
        enc_idle  = ($urandom_range(0, 3) != 0);
        swap_req  = (mode == 1) && (cyc == 4);
        @(negedge CLK);
        cyc++;
      end
      swap_req = 1'b0;
      if (mode == 1) pend_m = 1'b1;
      check("rnd_done", 32'(done_cnt), 32'(base + 1));
      check("rnd_buf_sel", 32'(buf_sel), 32'(bank_m));
      check_frame("rnd", bank_m);
    end
    pix_ready = 1'b1;
    enc_idle  = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_refresh_sequencer.md
Name: frame_refresh_sequencer

Overview:
Sequences one display refresh of the LED matrix. Walks the pixel frame buffer in address order and fetches each 24-bit colour word. Hands each word to the serial bit encoder over a valid/ready handshake, waits for the encoder to drain, then enforces the latch/reset gap on the LED chain. Owns front/back buffer selection, so SPI-side writes to the back bank never tear a frame being shown.

Parameters:
NUM_PIXELS, 64, pixels per frame (≥2)
ADDR_W, 6, pixel address width, clog2(NUM_PIXELS)
GAP_CYCLES, 600, CLK cycles of idle-low line after last bit (latch gap, ≥2)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
frame_req  input  1  request one frame refresh (level sampled each cycle)
swap_req  input  1  writer has finished filling back bank (level sampled)
swap_ack  output  1  one-cycle pulse when bank swap takes effect
buf_sel  output  1  bank currently displayed (0/1)
mem_rd_en  output  1  frame-buffer read strobe
mem_rd_addr  output  ADDR_W+1  {buf_sel, pixel index}
mem_rd_data  input  24  read data, valid exactly 1 cycle after mem_rd_en
pix_valid  output  1  pix_data holds a pixel for the encoder
pix_data  output  24  GRB pixel word
pix_ready  input  1  encoder accepts pix_data this cycle
enc_idle  input  1  encoder shift register empty, line low
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse at end of latch gap

Behaviour:
- Reset values: all outputs 0; buf_sel=0; state IDLE; index=0; pending flags clear.
- Outputs registered, except mem_rd_en and mem_rd_addr, which decode from state/index/buf_sel.
- States: IDLE, FETCH, WAIT, PRESENT, DRAIN, GAP.
- IDLE:
  - frame_req or req_pend → FETCH, index=0.
  - If swap_pend is set in that same transition: toggle buf_sel, pulse swap_ack, clear swap_pend.
  - The first FETCH reads the new bank.
- FETCH (1 cycle): mem_rd_en=1, addr={buf_sel,index} → WAIT.
- WAIT (1 cycle): capture mem_rd_data into pix_data, set pix_valid → PRESENT.
- Latency: frame_req sampled at edge N; mem_rd_en high during cycle N+1; pix_valid high from edge N+3.
- PRESENT: pix_valid held, pix_data stable until the handshake (pix_valid & pix_ready) completes. On handshake, pix_valid clears the same edge, then:
  - index<NUM_PIXELS-1: index++ → FETCH.
  - otherwise → DRAIN.
- DRAIN: wait for enc_idle=1 → GAP, gap counter loaded with GAP_CYCLES-1.
- GAP: decrement each cycle. At 0: pulse frame_done, then:
  - req_pend set → FETCH directly: clear req_pend, index=0, apply pending swap as in IDLE.
  - otherwise → IDLE.
- Frame length: GAP lasts exactly GAP_CYCLES cycles; frame_done asserts in the cycle after the last GAP cycle.
- frame_req while busy: sets req_pend. Multiple requests collapse to one; no queueing.
- swap_req sets swap_pend at any time. It is applied only at frame start, never mid-frame. swap_req and frame_req in the same IDLE cycle: swap applies to that frame.
- Index wrap: never wraps mid-frame; reset to 0 only at frame start.
- pix_ready high outside PRESENT is ignored.
- RESET mid-frame: immediate return to reset values. pix_valid drops asynchronously and no frame_done is issued. Line-level recovery is the encoder's responsibility.

Decomposition:
- Shared package led_matrix_pkg holds:
  - PIXEL_W=24
  - state enum fsm_state_t
  - default GAP_CYCLES and NUM_PIXELS constants, also used by the encoder and SPI writer.
- One sub-module: led_gap_timer. Loadable down-counter with inputs load, load_val and outputs zero. It owns the GAP counting and keeps the FSM small.

Test Plan:
1. Reset then single frame_req pulse, NUM_PIXELS=4, GAP_CYCLES=10, memory word = 0x0A0B00+addr, pix_ready always 1 → pix_data sequence 0x0A0B00..03. mem_rd_en at N+1; first pix_valid at N+3; frame_done 10 cycles after DRAIN exit; busy low afterwards.
2. Backpressure: pix_ready low for 5 cycles on pixel 2 → pix_valid stays high, pix_data unchanged for 5 cycles, no read issued; sequence otherwise identical.
3. frame_req pulsed three times during GAP → exactly one follow-on frame starting FETCH directly after the gap; exactly two frame_done pulses total.
4. swap_req mid-frame → buf_sel unchanged until next frame start. Then swap_ack pulse, buf_sel=1, and the first mem_rd_addr of that frame is 0x40 (ADDR_W=6).
5. DRAIN: hold enc_idle low 20 cycles after last handshake → GAP entry delayed exactly 20 cycles.
6. Assert RESET while in PRESENT → pix_valid, busy, mem_rd_en, buf_sel go 0 immediately. A new frame_req after release runs a clean frame from index 0.
